// File: rtl/uart_mon_capture.sv
// uart_mon_capture: S1D13700 host-bus monitor that timestamps accesses and queues 18-bit records for a UART.
// Define UART_MON_RD_EN to also capture read strobes (type 2'b10); otherwise lcd_rd_x is ignored.
module uart_mon_capture #(
    parameter int FIFO_AW = 4,
    parameter int TS_DIV  = 48
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        mon_en,
    input  logic        lcd_cs_x,
    input  logic        lcd_wr_x,
    input  logic        lcd_rd_x,
    input  logic        lcd_a0,
    input  logic [7:0]  lcd_d,
    output logic        uart_req,
    input  logic        uart_ack,
    output logic [17:0] uart_dat,
    output logic        mon_ovf
);
    localparam int          DEPTH   = 2 ** FIFO_AW;
    localparam logic [15:0] TS_LAST = 16'(TS_DIV - 1);

    // strobe chain bits: [1] cs_x, [0] wr_x; bus chain bits: [8] a0, [7:0] d
    logic [1:0]         strb_s1_q, strb_s1_d, strb_s2_q, strb_s2_d, strb_p_q, strb_p_d;
    logic [8:0]         bus_s1_q, bus_s1_d, bus_s2_q, bus_s2_d, bus_p_q, bus_p_d;
    logic [15:0]        presc_q, presc_d;
    logic [7:0]         delta_q, delta_d;
    logic [7:0]         lost_q, lost_d;
    logic               mon_ovf_q, mon_ovf_d;
    logic               uart_req_q, uart_req_d;
    logic [17:0]        uart_dat_q, uart_dat_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [17:0]        mem_q [DEPTH];

    logic        tick, wr_ev, rd_ev, ev, full, pop, can_wr, push;
    logic [1:0]  ev_type;
    logic [7:0]  lost_inc;
    logic [17:0] push_dat;

`ifdef UART_MON_RD_EN
    logic rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d, rd_p_q, rd_p_d;
    assign rd_ev = mon_en && rd_s2_q && !rd_p_q && !strb_p_q[1];
`else
    logic unused_rd;
    assign unused_rd = lcd_rd_x;
    assign rd_ev     = 1'b0;
`endif

    assign wr_ev   = mon_en && strb_s2_q[0] && !strb_p_q[0] && !strb_p_q[1];
    assign ev      = wr_ev || rd_ev;
    assign ev_type = wr_ev ? {1'b0, bus_p_q[8]} : 2'b10;
    assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));

    always_comb begin
        strb_s1_d = {lcd_cs_x, lcd_wr_x};
        strb_s2_d = strb_s1_q;
        strb_p_d  = strb_s2_q;
        bus_s1_d  = {lcd_a0, lcd_d};
        bus_s2_d  = bus_s1_q;
        bus_p_d   = bus_s2_q;
`ifdef UART_MON_RD_EN
        rd_s1_d   = lcd_rd_x;
        rd_s2_d   = rd_s1_q;
        rd_p_d    = rd_s2_q;
`endif
    end

    always_comb begin
        tick    = (presc_q == TS_LAST);
        presc_d = tick ? '0 : presc_q + 16'd1;
        delta_d = delta_q;
        if (ev)
            delta_d = '0;
        else if (tick && delta_q != 8'hFF)
            delta_d = delta_q + 8'd1;

        // a pop frees a slot in the same cycle, so a full FIFO can still accept
        pop       = !uart_req_q && (count_q != '0);
        can_wr    = !full || pop;
        lost_inc  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        push      = 1'b0;
        push_dat  = {ev_type, delta_q, bus_p_q[7:0]};
        lost_d    = lost_q;
        mon_ovf_d = mon_ovf_q;
        if (!mon_en) begin
            lost_d    = '0;
            mon_ovf_d = 1'b0;
        end else if (lost_q != '0 && can_wr) begin
            push     = 1'b1;
            push_dat = {2'b11, 8'h00, ev ? lost_inc : lost_q};
            lost_d   = '0;
        end else if (ev && can_wr) begin
            push = 1'b1;
        end else if (ev) begin
            lost_d    = lost_inc;
            mon_ovf_d = 1'b1;
        end

        uart_req_d = uart_req_q;
        uart_dat_d = uart_dat_q;
        if (uart_req_q && uart_ack) begin
            uart_req_d = 1'b0;
        end else if (pop) begin
            uart_req_d = 1'b1;
            uart_dat_d = mem_q[rd_ptr_q];
        end

        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            strb_s1_q  <= '1;
            strb_s2_q  <= '1;
            strb_p_q   <= '1;
            bus_s1_q   <= '0;
            bus_s2_q   <= '0;
            bus_p_q    <= '0;
            presc_q    <= '0;
            delta_q    <= '0;
            lost_q     <= '0;
            mon_ovf_q  <= 1'b0;
            uart_req_q <= 1'b0;
            uart_dat_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_MON_RD_EN
            rd_s1_q    <= 1'b1;
            rd_s2_q    <= 1'b1;
            rd_p_q     <= 1'b1;
`endif
        end else begin
            strb_s1_q  <= strb_s1_d;
            strb_s2_q  <= strb_s2_d;
            strb_p_q   <= strb_p_d;
            bus_s1_q   <= bus_s1_d;
            bus_s2_q   <= bus_s2_d;
            bus_p_q    <= bus_p_d;
            presc_q    <= presc_d;
            delta_q    <= delta_d;
            lost_q     <= lost_d;
            mon_ovf_q  <= mon_ovf_d;
            uart_req_q <= uart_req_d;
            uart_dat_q <= uart_dat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef UART_MON_RD_EN
            rd_s1_q    <= rd_s1_d;
            rd_s2_q    <= rd_s2_d;
            rd_p_q     <= rd_p_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_dat;
    end

    assign uart_req = uart_req_q;
    assign uart_dat = uart_dat_q;
    assign mon_ovf  = mon_ovf_q;
endmodule
